fuzz_round_sequencer: RTL
=========================

// Module: fuzz_round_sequencer
// PURPOSE
//  Sequences each fuzzing round of the DUT: reset, testcase-load handshake, run, end detection, host report.
//  Detects round end from tohost[0], coverage stall, watchdog or hard timeout.
//  On stall or watchdog, drives the DUT interrupt line so the testcase can trap and exit cleanly.
//  Sits in Testbench between the coverage probe/tohost and the host-side loader (DPI, memory preload).
// PARAMETERS
//  COV_W         30          width of coverage sum input
//  STALL_BASE    1000        stall threshold per coverage band
//  STALL_SHIFT   19          band = cov >> STALL_SHIFT
//  WATCHDOG_MAX  50000       RUN cycles before interrupt regardless of coverage
//  TIMEOUT_MAX   2000000000  RUN+DRAIN cycles before forced end, 64-bit
//  RESET_CYCLES  4           DUT reset hold cycles, >=1
// PORTS
//  clock          in   1      sole clock, all logic on posedge
//  reset          in   1      synchronous, active-high
//  start          in   1      begin first round, sampled in IDLE only
//  cov            in   COV_W  DUT coverage sum
//  tohost         in   64     DUT tohost; bit0 = testcase finished
//  dut_reset      out  1      DUT reset
//  load_req       out  1      host must load testcase hex/elf
//  load_ack       in   1      host load complete
//  interrupt      out  1      stall/watchdog interrupt to DUT
//  round_done     out  1      report valid, held until done_ack
//  round_status   out  3      0 none, 1 pass, 2 stall, 3 watchdog, 4 timeout
//  round_cycles   out  64     cycles spent in RUN+DRAIN for the reported round
//  done_ack       in   1      host consumed report
//  done_continue  in   1      sampled with done_ack: 1 = next round, 0 = stop
//  busy           out  1      state != IDLE
//  round_count    out  32     completed rounds, wraps at 2^32
// BEHAVIOUR
//  Reset values:
//   - state IDLE, dut_reset=1; all other outputs 0, counters 0.
//   - reset mid-round aborts immediately, no report.
//  IDLE:
//   - dut_reset=1.
//   - start=1 -> RESET next cycle.
//  RESET:
//   - dut_reset=1 for exactly RESET_CYCLES cycles, then LOAD.
//  LOAD:
//   - dut_reset=1, load_req=1.
//   - load_ack=1 -> RUN next cycle; load_req drops the same edge.
//   - load_ack outside LOAD is ignored.
//  RUN:
//   - dut_reset=0.
//   - cyc, stall and wdog counters cleared on entry.
//   - cyc increments every RUN/DRAIN cycle; wdog increments every RUN cycle.
//   - stall: cleared when cov != previous-cycle cov, else increments.
//   - stall threshold = STALL_BASE*((cov>>STALL_SHIFT)+1), 64-bit arithmetic, no overflow.
//   - Evaluation priority within one cycle:
//     - tohost[0] -> REPORT, status 1.
//     - else cyc >= TIMEOUT_MAX -> REPORT, status 4.
//     - else wdog >= WATCHDOG_MAX -> DRAIN, cause 3.
//     - else stall >= threshold -> DRAIN, cause 2.
//  DRAIN:
//   - interrupt=1, held until exit; cause latched on entry.
//   - tohost[0] -> REPORT, status = latched cause.
//   - cyc >= TIMEOUT_MAX -> REPORT, status 4.
//   - tohost[0] and timeout in the same cycle -> latched cause wins.
//  REPORT:
//   - dut_reset=1, interrupt=0.
//   - round_done=1; round_status and round_cycles stable until ack.
//   - round_count increments on REPORT entry.
//   - done_ack=1 and done_continue=1 -> RESET; done_ack=1 and done_continue=0 -> IDLE.
//   - round_done drops the cycle after ack.
//  round_cycles: latched cyc value on the REPORT-entry edge, including the terminating cycle.
//  start asserted outside IDLE is ignored.
// STRUCTURE
//  Package fuzz_seq_pkg:
//   - state_e {IDLE,RESET,LOAD,RUN,DRAIN,REPORT}.
//   - status_e encodings 0..4.
//  Sub-module fuzz_stall_detector:
//   - owns prev-cov register, stall and wdog counters, threshold compare.
//   - outputs stall_hit and wdog_hit; clear input pulsed on RUN entry.
//  Top holds the FSM, cycle counter and report registers.
// TESTING (STALL_BASE=10, STALL_SHIFT=4, WATCHDOG_MAX=200, TIMEOUT_MAX=500, RESET_CYCLES=4)
//  1. Pass: start, load_ack 3 cycles after load_req, cov ramps every cycle, tohost=1 at RUN cycle 50
//     -> status 1, round_cycles 50, round_count 1, interrupt never high.
//  2. Stall: cov frozen at 5 -> interrupt rises after 10 RUN cycles; tohost at 20 -> status 2.
//     Repeat with cov=40 (band 2): interrupt after 30 cycles.
//  3. Watchdog: cov changes every cycle -> interrupt at RUN cycle 200; tohost at 210 -> status 3.
//  4. Timeout: cov frozen, no tohost -> round_done with status 4, round_cycles 500.
//     Same-cycle tohost+timeout in DRAIN -> status 2.
//  5. Multi-round: done_continue=1 twice, then 0 -> three reports, round_count 3, IDLE, dut_reset=1.
//     Ack held off 20 cycles keeps report stable.
//  6. Reset mid-RUN -> next cycle IDLE, round_done=0, round_count 0, dut_reset=1.
//     Stray load_ack/start in RUN ignored.

Source files
------------

// File: rtl/fuzz_seq_pkg.sv
// Shared types and helpers for the fuzz round sequencer.
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        LOAD,
        RUN,
        DRAIN,
        REPORT
    } state_e;

    typedef enum logic [2:0] {
        STATUS_NONE    = 3'd0,
        STATUS_PASS    = 3'd1,
        STATUS_STALL   = 3'd2,
        STATUS_WDOG    = 3'd3,
        STATUS_TIMEOUT = 3'd4
    } status_e;

    // Stall limit grows with the coverage band so mature testcases get more slack.
    function automatic logic [63:0] stall_threshold(input logic [63:0] base,
                                                    input logic [63:0] cov64,
                                                    input int unsigned shift);
        return base * ((cov64 >> shift) + 64'd1);
    endfunction

endpackage

// File: rtl/fuzz_stall_detector.sv
// Coverage-stall and watchdog detection for the RUN phase of a fuzz round.
module fuzz_stall_detector
    import fuzz_seq_pkg::*;
#(
    parameter int unsigned COV_W        = 30,
    parameter logic [63:0] STALL_BASE   = 64'd1000,
    parameter int unsigned STALL_SHIFT  = 19,
    parameter logic [63:0] WATCHDOG_MAX = 64'd50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [COV_W-1:0] cov,
    output logic             stall_hit,
    output logic             wdog_hit
);

    logic [COV_W-1:0] prev_cov_q;
    logic [63:0]      stall_q;
    logic [63:0]      wdog_q;
    logic [63:0]      stall_cur;
    logic [63:0]      wdog_cur;
    logic [63:0]      threshold;

    // Counter values including the current cycle, compared against their limits.
    always_comb begin
        stall_cur = (cov == prev_cov_q) ? stall_q + 64'd1 : '0;
        wdog_cur  = wdog_q + 64'd1;
        threshold = stall_threshold(STALL_BASE, 64'(cov), STALL_SHIFT);
        stall_hit = run && (stall_cur >= threshold);
        wdog_hit  = run && (wdog_cur >= WATCHDOG_MAX);
    end

    // Previous-cov tracking runs always; counters clear on RUN entry and advance only in RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_cov_q <= '0;
            stall_q    <= '0;
            wdog_q     <= '0;
        end else begin
            prev_cov_q <= cov;
            if (clear) begin
                stall_q <= '0;
                wdog_q  <= '0;
            end else if (run) begin
                stall_q <= stall_cur;
                wdog_q  <= wdog_cur;
            end
        end
    end

endmodule

// File: rtl/fuzz_round_sequencer.sv
// Per-round fuzzing sequencer: DUT reset, testcase load, run, end detection, host report.
module fuzz_round_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int unsigned COV_W        = 30,
    parameter logic [63:0] STALL_BASE   = 64'd1000,
    parameter int unsigned STALL_SHIFT  = 19,
    parameter logic [63:0] WATCHDOG_MAX = 64'd50000,
    parameter logic [63:0] TIMEOUT_MAX  = 64'd2000000000,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [COV_W-1:0] cov,
    input  logic [63:0]      tohost,
    output logic             dut_reset,
    output logic             load_req,
    input  logic             load_ack,
    output logic             interrupt,
    output logic             round_done,
    output logic [2:0]       round_status,
    output logic [63:0]      round_cycles,
    input  logic             done_ack,
    input  logic             done_continue,
    output logic             busy,
    output logic [31:0]      round_count
);

    state_e      state_q, state_d;
    status_e     cause_q, drain_cause, report_status, round_status_q;
    logic [31:0] rst_cnt_q;
    logic [63:0] cyc_q, cyc_cur, round_cycles_q;
    logic [31:0] round_count_q;
    logic        run_clear, drain_en, report_en;
    logic        timeout_hit, stall_hit, wdog_hit;
    logic        unused_tohost;

    assign unused_tohost = ^tohost[63:1];

    // cyc_cur counts the current cycle, so the terminating cycle is included in the report.
    assign cyc_cur     = cyc_q + 64'd1;
    assign timeout_hit = cyc_cur >= TIMEOUT_MAX;

    fuzz_stall_detector #(
        .COV_W        (COV_W),
        .STALL_BASE   (STALL_BASE),
        .STALL_SHIFT  (STALL_SHIFT),
        .WATCHDOG_MAX (WATCHDOG_MAX)
    ) u_stall (
        .clock     (clock),
        .reset     (reset),
        .clear     (run_clear),
        .run       (state_q == RUN),
        .cov       (cov),
        .stall_hit (stall_hit),
        .wdog_hit  (wdog_hit)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and round-end decisions in priority order.
    always_comb begin
        state_d       = state_q;
        run_clear     = 1'b0;
        drain_en      = 1'b0;
        drain_cause   = STATUS_NONE;
        report_en     = 1'b0;
        report_status = STATUS_NONE;
        case (state_q)
            IDLE: if (start) state_d = RESET;
            RESET: if (rst_cnt_q == 32'(RESET_CYCLES - 1)) state_d = LOAD;
            LOAD: if (load_ack) begin
                state_d   = RUN;
                run_clear = 1'b1;
            end
            RUN: begin
                if (tohost[0]) begin
                    state_d = REPORT; report_en = 1'b1; report_status = STATUS_PASS;
                end else if (timeout_hit) begin
                    state_d = REPORT; report_en = 1'b1; report_status = STATUS_TIMEOUT;
                end else if (wdog_hit) begin
                    state_d = DRAIN; drain_en = 1'b1; drain_cause = STATUS_WDOG;
                end else if (stall_hit) begin
                    state_d = DRAIN; drain_en = 1'b1; drain_cause = STATUS_STALL;
                end
            end
            DRAIN: begin
                if (tohost[0]) begin
                    state_d = REPORT; report_en = 1'b1; report_status = cause_q;
                end else if (timeout_hit) begin
                    state_d = REPORT; report_en = 1'b1; report_status = STATUS_TIMEOUT;
                end
            end
            REPORT: if (done_ack) state_d = done_continue ? RESET : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round counters, drain cause and report registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt_q      <= '0;
            cyc_q          <= '0;
            cause_q        <= STATUS_NONE;
            round_status_q <= STATUS_NONE;
            round_cycles_q <= '0;
            round_count_q  <= '0;
        end else begin
            rst_cnt_q <= (state_q == RESET) ? rst_cnt_q + 32'd1 : '0;
            if (run_clear)
                cyc_q <= '0;
            else if (state_q == RUN || state_q == DRAIN)
                cyc_q <= cyc_cur;
            if (drain_en)
                cause_q <= drain_cause;
            if (report_en) begin
                round_status_q <= report_status;
                round_cycles_q <= cyc_cur;
                round_count_q  <= round_count_q + 32'd1;
            end
        end
    end

    assign dut_reset    = (state_q != RUN) && (state_q != DRAIN);
    assign load_req     = (state_q == LOAD);
    assign interrupt    = (state_q == DRAIN);
    assign round_done   = (state_q == REPORT);
    assign busy         = (state_q != IDLE);
    assign round_status = round_status_q;
    assign round_cycles = round_cycles_q;
    assign round_count  = round_count_q;

endmodule
